stopwatch_seq: RTL
==================

Name: stopwatch_seq

Overview:
Mode sequencer for the stopwatch datapath. Turns the three raw pushbuttons into conditioned press events and runs an IDLE/RUN/PAUSE/LAP_HOLD state machine. It drives the time counter enable and clear, and issues the one-cycle lap strobe that the best-interval tracker samples. It also clears the tracker and selects the live or held display.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
DEBOUNCE_MS, 20, key stability window; DB_CYC = CLK_HZ/1000*DEBOUNCE_MS
HOLD_MS, 2000, lap display hold time; HOLD_CYC = CLK_HZ/1000*HOLD_MS

Ports:
clk  in  1  system clock; the block's only clock
rst  in  1  asynchronous, active-high reset
key_start_n  in  1  raw start/stop button, active-low, asynchronous to clk
key_lap_n  in  1  raw lap button, active-low, asynchronous
key_clear_n  in  1  raw clear button, active-low, asynchronous
cnt_en  out  1  time counter run enable
cnt_clr  out  1  one-cycle pulse that zeroes the time counter
lap_strb  out  1  one-cycle pulse; drives key_interval of the interval tracker
lap_clr  out  1  one-cycle pulse that clears the tracker's registered/best state
disp_sel  out  1  0 = live time, 1 = held lap/best interval
state  out  2  current state, encoded with sw_state_t

Behaviour:
- One clock domain (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, cnt_en=0, cnt_clr=0, lap_strb=0, lap_clr=0, disp_sel=0. Synchronizers, debounce counters and hold timer all clear to zero. Debounced key levels reset to released (1).
- Key conditioning, per key:
  - 2-FF synchronizer.
  - Counter counts consecutive synced samples that differ from the debounced level. At DB_CYC it updates the level and zeroes the counter. Any sample equal to the current level zeroes the counter.
  - Press event = debounced 1->0 transition, registered, exactly one cycle long.
  - Latency from raw stable edge to press event: 2+DB_CYC+1 cycles.
  - Glitches shorter than DB_CYC produce no event. Release produces no event.
- Event arbitration: at most one event is accepted per cycle. Priority is start > lap > clear; lower-priority events in the same cycle are dropped.
- All outputs are registered and change on the clk edge after the accepted event.
- IDLE (cnt_en=0, disp_sel=0):
  - start -> RUN.
  - clear -> cnt_clr and lap_clr pulse; stay in IDLE.
  - lap is ignored.
- RUN (cnt_en=1, disp_sel=0):
  - start -> PAUSE.
  - lap -> lap_strb pulse and go to LAP_HOLD; hold timer loads HOLD_CYC-1.
  - clear is ignored.
- LAP_HOLD (cnt_en=1, disp_sel=1):
  - Hold timer decrements every cycle. When it is 0, go to RUN next edge, so disp_sel is high for exactly HOLD_CYC cycles.
  - lap -> another lap_strb pulse; timer reloads HOLD_CYC-1; stay in LAP_HOLD.
  - start -> PAUSE; disp_sel drops with the transition.
  - Timer expiry in the same cycle as a lap event: the lap wins (reload).
  - Timer expiry in the same cycle as a start event: go to PAUSE.
- PAUSE (cnt_en=0, disp_sel=0):
  - start -> RUN.
  - clear -> cnt_clr and lap_clr pulse; go to IDLE.
  - lap is ignored.
- lap_strb is never asserted while cnt_en=0.
- cnt_clr and lap_clr are always coincident and never asserted while cnt_en=1.
- Reset mid-operation (any state, including a partial debounce or running hold): immediate return to reset values. A key still held when rst deasserts produces no press until it is released and pressed again.
- Hold timer width is $clog2(HOLD_CYC). Debounce counter width is $clog2(DB_CYC+1). Neither counter wraps; both saturate by construction.

Decomposition:
- time_pkg gains:
  - typedef enum logic [1:0] sw_state_t {IDLE=0, RUN=1, PAUSE=2, LAP_HOLD=3}
  - function ms_to_cyc(clk_hz, ms) for DB_CYC/HOLD_CYC
- One sub-module, key_cond: synchronizer, debounce counter and press-edge detector, parameterized by DB_CYC. Instantiated three times.
- The FSM, arbitration and hold timer stay in stopwatch_seq.

Test Plan:
Sim params for all scenarios: CLK_HZ=10_000, DEBOUNCE_MS=1, HOLD_MS=5, giving DB_CYC=10 and HOLD_CYC=50.
1. Reset, then hold key_start_n low for 20 cycles -> cnt_en rises exactly 14 cycles after the raw edge, state=RUN. The 9-cycle and 5-cycle low glitches before it cause no change.
2. In RUN, press lap -> a single lap_strb of 1 cycle; disp_sel=1 for exactly 50 cycles, then state=RUN. cnt_en stays 1 throughout.
3. In LAP_HOLD, press lap again at hold cycle 30 -> second lap_strb; disp_sel remains 1 for a further 50 cycles from the reload.
4. Start and lap press events in the same cycle while in RUN -> state=PAUSE, cnt_en=0, no lap_strb.
5. From PAUSE, press clear -> cnt_clr and lap_clr high together for 1 cycle, state=IDLE. Clear pressed in RUN -> no pulse.
6. Assert rst while in LAP_HOLD with key_lap_n held low -> all outputs 0, state=IDLE within the same cycle (async). After rst drops, no lap event until the key is released and re-pressed.

Source files
------------

// File: rtl/time_pkg.sv
// Shared types and helpers for the stopwatch timing blocks.
package time_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        PAUSE    = 2'd2,
        LAP_HOLD = 2'd3
    } sw_state_t;

    function automatic int ms_to_cyc(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/key_cond.sv
// Pushbutton conditioner: 2-FF synchronizer, debounce counter and a one-cycle
// press pulse on the debounced 1->0 transition.
module key_cond #(
    parameter int DB_CYC = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYC);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic          armed;
    logic [CW-1:0] db_cnt;

    // armed stays low until the key has been seen released, so a key held
    // through reset cannot produce a press when reset drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b1;
            armed  <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b) begin
                armed <= 1'b1;
            end
            if (sync_b == level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_MAX) begin
                level  <= sync_b;
                db_cnt <= '0;
                press  <= level & armed;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_seq.sv
// Stopwatch mode sequencer: conditions the three buttons and runs the
// IDLE/RUN/PAUSE/LAP_HOLD machine driving counter, tracker and display controls.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | stopped and cleared; start runs, clear pulses the clears
//   RUN      | counter enabled, live display
//   PAUSE    | counter frozen; start resumes, clear returns to IDLE
//   LAP_HOLD | counter enabled, held lap shown until hold timer expires
module stopwatch_seq
    import time_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int HOLD_MS     = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    input  logic       key_clear_n,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       lap_strb,
    output logic       lap_clr,
    output logic       disp_sel,
    output logic [1:0] state
);

    localparam int DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int HOLD_CYC = ms_to_cyc(CLK_HZ, HOLD_MS);
    localparam int HW       = $clog2(HOLD_CYC);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

    logic ev_start;
    logic ev_lap;
    logic ev_clear;
    logic acc_start;
    logic acc_lap;
    logic acc_clear;

    sw_state_t     state_q;
    sw_state_t     state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          strb_d;
    logic          clr_d;

    key_cond #(.DB_CYC(DB_CYC)) u_key_start (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_start_n),
        .press (ev_start)
    );

    key_cond #(.DB_CYC(DB_CYC)) u_key_lap (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_lap_n),
        .press (ev_lap)
    );

    key_cond #(.DB_CYC(DB_CYC)) u_key_clear (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_clear_n),
        .press (ev_clear)
    );

    // Fixed priority start > lap > clear; losers in the same cycle are dropped.
    assign acc_start = ev_start;
    assign acc_lap   = ev_lap & ~ev_start;
    assign acc_clear = ev_clear & ~ev_start & ~ev_lap;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        strb_d  = 1'b0;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_start) begin
                    state_d = RUN;
                end else if (acc_clear) begin
                    clr_d = 1'b1;
                end
            end
            RUN: begin
                if (acc_start) begin
                    state_d = PAUSE;
                end else if (acc_lap) begin
                    strb_d  = 1'b1;
                    hold_d  = HOLD_LOAD;
                    state_d = LAP_HOLD;
                end
            end
            LAP_HOLD: begin
                // A lap on the expiry cycle reloads rather than returning to RUN.
                if (acc_start) begin
                    state_d = PAUSE;
                    hold_d  = '0;
                end else if (acc_lap) begin
                    strb_d = 1'b1;
                    hold_d = HOLD_LOAD;
                end else if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            PAUSE: begin
                if (acc_start) begin
                    state_d = RUN;
                end else if (acc_clear) begin
                    clr_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            cnt_en   <= 1'b0;
            cnt_clr  <= 1'b0;
            lap_strb <= 1'b0;
            lap_clr  <= 1'b0;
            disp_sel <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            cnt_en   <= (state_d == RUN) || (state_d == LAP_HOLD);
            cnt_clr  <= clr_d;
            lap_strb <= strb_d;
            lap_clr  <= clr_d;
            disp_sel <= (state_d == LAP_HOLD);
        end
    end

    assign state = state_q;

endmodule
